// File: rtl/divider_16by8.sv
// Sequential signed restoring divider: 16-bit dividend by 8-bit divisor, one quotient bit per
// cycle on magnitudes, signs and saturation applied in a final fix-up cycle.
module divider_16by8 #(
  parameter int unsigned DIVIDEND_W = 16,
  parameter int unsigned DIVISOR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  data_valid,
  output logic [DIVISOR_W-1:0]  quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  overflow,
  output logic                  div_by_zero
);

  localparam int unsigned CntW = $clog2(DIVIDEND_W);
  localparam logic [CntW-1:0] CntLast = CntW'(DIVIDEND_W - 1);
  localparam logic [DIVIDEND_W-1:0] PosLimit = DIVIDEND_W'(2 ** (DIVISOR_W - 1) - 1);
  localparam logic [DIVIDEND_W-1:0] NegLimit = DIVIDEND_W'(2 ** (DIVISOR_W - 1));
  localparam logic [DIVISOR_W-1:0] SatPos = {1'b0, {(DIVISOR_W - 1){1'b1}}};
  localparam logic [DIVISOR_W-1:0] SatNeg = {1'b1, {(DIVISOR_W - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StDiv, StFix} state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [DIVIDEND_W-1:0] dvd_q;
  logic [DIVIDEND_W-1:0] quo_q;
  logic [DIVISOR_W:0]    rem_q;
  logic [DIVISOR_W-1:0]  dvs_q;
  logic                  sign_a_q;
  logic                  sign_b_q;
  logic                  dvs_zero_q;

  // Partial remainder with the next dividend bit shifted in, one bit wider than rem_q.
  logic [DIVISOR_W+1:0]  rem_shift;
  logic                  trial_ok;

  logic                  neg_q;
  logic                  fix_ovf;
  logic [DIVISOR_W-1:0]  fix_quo;
  logic [DIVISOR_W-1:0]  fix_rem;

  always_comb begin
    rem_shift = {rem_q, dvd_q[DIVIDEND_W-1]};
    trial_ok  = rem_shift >= {2'b00, dvs_q};
  end

  always_comb begin
    neg_q   = sign_a_q ^ sign_b_q;
    fix_ovf = neg_q ? (quo_q > NegLimit) : (quo_q > PosLimit);
    fix_quo = neg_q ? -quo_q[DIVISOR_W-1:0] : quo_q[DIVISOR_W-1:0];
    fix_rem = sign_a_q ? -rem_q[DIVISOR_W-1:0] : rem_q[DIVISOR_W-1:0];
    if (dvs_zero_q) begin
      fix_ovf = 1'b0;
      fix_quo = sign_a_q ? SatNeg : SatPos;
      fix_rem = '0;
    end else if (fix_ovf) begin
      fix_quo = neg_q ? SatNeg : SatPos;
      fix_rem = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      dvd_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      dvs_zero_q  <= 1'b0;
      busy        <= 1'b0;
      data_valid  <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            dvd_q      <= dividend[DIVIDEND_W-1] ? -dividend : dividend;
            dvs_q      <= divisor[DIVISOR_W-1] ? -divisor : divisor;
            sign_a_q   <= dividend[DIVIDEND_W-1];
            sign_b_q   <= divisor[DIVISOR_W-1];
            dvs_zero_q <= (divisor == '0);
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            busy       <= 1'b1;
            state_q    <= StDiv;
          end
        end
        StDiv: begin
          rem_q <= trial_ok ? (DIVISOR_W + 1)'(rem_shift - {2'b00, dvs_q})
                            : rem_shift[DIVISOR_W:0];
          quo_q <= {quo_q[DIVIDEND_W-2:0], trial_ok};
          dvd_q <= {dvd_q[DIVIDEND_W-2:0], 1'b0};
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          quotient    <= fix_quo;
          remainder   <= fix_rem;
          overflow    <= fix_ovf;
          div_by_zero <= dvs_zero_q;
          data_valid  <= 1'b1;
          busy        <= 1'b0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_16by8.sv
// Directed-vector and random back-to-back bench for divider_16by8.
module tb_divider_16by8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        data_valid;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        overflow;
  logic        div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  divider_16by8 #(
    .DIVIDEND_W(16),
    .DIVISOR_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .data_valid (data_valid),
    .quotient   (quotient),
    .remainder  (remainder),
    .overflow   (overflow),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        ovf;
    logic        dbz;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference: {ovf, dbz, q, r} from plain integer division.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [7:0] b);
    int sa;
    int sb;
    int qt;
    int rt;
    logic [7:0] q;
    logic [7:0] r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sb == 0) return {1'b0, 1'b1, (sa >= 0) ? 8'h7F : 8'h80, 8'h00};
    qt = sa / sb;
    rt = sa % sb;
    if (qt > 127) return {1'b1, 1'b0, 8'h7F, 8'h00};
    if (qt < -128) return {1'b1, 1'b0, 8'h80, 8'h00};
    q = qt[7:0];
    r = rt[7:0];
    return {1'b0, 1'b0, q, r};
  endfunction

  // Issues one start pulse; returns samples-until-data_valid and busy-high sample count.
  task automatic do_op(input logic [15:0] a, input logic [7:0] b, output int lat,
                       output int bcnt);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    bcnt  = 0;
    while (!data_valid && lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_dv(output int lat);
    lat = 0;
    while (!data_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  vec_t vecs[16];

  initial begin
    int lat;
    int bcnt;
    int dv_seen;
    int done;
    int cyc;
    int last_dv;
    logic [17:0] exp_res;
    logic [15:0] pend_a;
    logic [7:0]  pend_b;
    logic [31:0] rnd;

    vecs[0]  = '{16'd100,        8'd7,       8'h0E, 8'h02, 1'b0, 1'b0};
    vecs[1]  = '{16'(-100),      8'd7,       8'hF2, 8'hFE, 1'b0, 1'b0};
    vecs[2]  = '{16'd100,        8'(-7),     8'hF2, 8'h02, 1'b0, 1'b0};
    vecs[3]  = '{16'(-100),      8'(-7),     8'h0E, 8'hFE, 1'b0, 1'b0};
    vecs[4]  = '{16'(-1024),     8'd8,       8'h80, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{16'd1024,       8'd8,       8'h7F, 8'h00, 1'b1, 1'b0};
    vecs[6]  = '{16'h8000,       8'hFF,      8'h7F, 8'h00, 1'b1, 1'b0};
    vecs[7]  = '{16'd32767,      8'h80,      8'h80, 8'h00, 1'b1, 1'b0};
    vecs[8]  = '{16'd500,        8'd0,       8'h7F, 8'h00, 1'b0, 1'b1};
    vecs[9]  = '{16'(-5),        8'd0,       8'h80, 8'h00, 1'b0, 1'b1};
    vecs[10] = '{16'd127,        8'd1,       8'h7F, 8'h00, 1'b0, 1'b0};
    vecs[11] = '{16'(-128),      8'd1,       8'h80, 8'h00, 1'b0, 1'b0};
    vecs[12] = '{16'd5,          8'(-7),     8'h00, 8'h05, 1'b0, 1'b0};
    vecs[13] = '{16'(-16384),    8'h80,      8'h7F, 8'h00, 1'b1, 1'b0};
    vecs[14] = '{16'(-16384),    8'd128,     8'h7F, 8'h00, 1'b1, 1'b0};
    vecs[15] = '{16'd16383,      8'h80,      8'h81, 8'h7F, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_state", {busy, data_valid, overflow, div_by_zero, quotient, remainder}, 0);

    for (int i = 0; i < 16; i++) begin
      do_op(vecs[i].a, vecs[i].b, lat, bcnt);
      check($sformatf("v%0d_latency", i), lat, 18);
      check($sformatf("v%0d_busy_cycles", i), bcnt, 17);
      check($sformatf("v%0d_busy_at_dv", i), busy, 0);
      check($sformatf("v%0d_result", i), {overflow, div_by_zero, quotient, remainder},
            {vecs[i].ovf, vecs[i].dbz, vecs[i].q, vecs[i].r});
      @(negedge clk);
      check($sformatf("v%0d_dv_pulse", i), data_valid, 0);
      check($sformatf("v%0d_hold", i), {overflow, div_by_zero, quotient, remainder},
            {vecs[i].ovf, vecs[i].dbz, vecs[i].q, vecs[i].r});
    end

    // A start raised while busy must be ignored.
    @(negedge clk);
    start = 1'b1; dividend = 16'd100; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; dividend = 16'(-2000); divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    wait_dv(lat);
    check("busy_start_dv", data_valid, 1);
    check("busy_start_result", {overflow, div_by_zero, quotient, remainder}, {2'b00, 16'h0E02});
    dv_seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (data_valid) dv_seen++;
    end
    check("busy_start_no_second", dv_seen, 0);

    // Reset mid-operation aborts without a result.
    @(negedge clk);
    start = 1'b1; dividend = 16'(-100); divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_outputs", {busy, data_valid, overflow, div_by_zero, quotient, remainder}, 0);
    dv_seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (data_valid) dv_seen++;
    end
    check("abort_no_dv", dv_seen, 0);
    do_op(16'(-100), 8'(-7), lat, bcnt);
    check("after_abort_latency", lat, 18);
    check("after_abort_result", {overflow, div_by_zero, quotient, remainder}, {2'b00, 16'h0EFE});

    // Back-to-back with start held high and operands changing every cycle.
    @(negedge clk);
    rnd = $urandom;
    pend_a = rnd[15:0]; pend_b = rnd[23:16];
    start = 1'b1; dividend = pend_a; divisor = pend_b;
    done = 0; cyc = 0; last_dv = -1;
    while (done < 1000 && cyc < 1000 * 18 + 100) begin
      @(negedge clk);
      cyc++;
      if (data_valid) begin
        if (last_dv >= 0) check("b2b_interval", cyc - last_dv, 18);
        last_dv = cyc;
        exp_res = model(pend_a, pend_b);
        check($sformatf("b2b_%0d_%h_%h", done, pend_a, pend_b),
              {overflow, div_by_zero, quotient, remainder}, exp_res);
        done++;
      end
      rnd = $urandom;
      dividend = rnd[31] ? {{5{rnd[10]}}, rnd[10:0]} : rnd[15:0];
      divisor  = (rnd[30:28] == 3'd0) ? 8'd0 : rnd[23:16];
      if (data_valid) begin
        pend_a = dividend;
        pend_b = divisor;
      end
    end
    start = 1'b0;
    check("b2b_count", done, 1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
